// File: rtl/ldst_mem_arbiter.sv
// Memory-stage scheduler: in-order store queue plus a single load slot sharing
// one data-memory port. Loads forward from aliasing queued stores, else win arbitration.
module ldst_mem_arbiter #(
  parameter int SQ_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      store_fifo_write_signal,
  input  logic                      load_fifo_write_signal,
  input  logic [ADDR_W-1:0]         addr_in,
  input  logic [DATA_W-1:0]         wdata_in,
  input  logic [4:0]                load_rd_in,
  output logic                      load_done,
  output logic [DATA_W-1:0]         load_data,
  output logic [4:0]                load_rd,
  output logic                      pipe_stall,
  output logic                      overflow,
  output logic [$clog2(SQ_DEPTH):0] sq_count,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int IW = $clog2(SQ_DEPTH);
  localparam int CW = IW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_BUSY = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [ADDR_W-1:0] sq_addr [SQ_DEPTH];
  logic [DATA_W-1:0] sq_data [SQ_DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [CW-1:0]     head, tail, count;
  logic [1:0]        state;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [4:0]        ld_rd;

  logic              sq_full, enq, ld_take, drop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [IW-1:0]     idx;

  assign count      = tail - head;
  assign sq_count   = count;
  assign sq_full    = (count == CW'(SQ_DEPTH));
  assign pipe_stall = sq_full | ld_valid;

  assign drop    = (store_fifo_write_signal & load_fifo_write_signal) |
                   (store_fifo_write_signal & sq_full) |
                   (load_fifo_write_signal & ld_valid);
  assign enq     = store_fifo_write_signal & ~load_fifo_write_signal & ~sq_full;
  assign ld_take = load_fifo_write_signal & ~store_fifo_write_signal & ~ld_valid;

  // Walk oldest to youngest so the last hit is the youngest aliasing store.
  // The in-flight head stays valid here until its ack dequeues it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head[IW-1:0] + IW'(i);
      if ((CW'(i) < count) && (sq_addr[idx] == addr_in)) begin
        fwd_hit  = 1'b1;
        fwd_data = sq_data[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      sq_addr[tail[IW-1:0]] <= addr_in;
      sq_data[tail[IW-1:0]] <= wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      state     <= IDLE;
      ld_valid  <= 1'b0;
      ld_addr   <= '0;
      ld_rd     <= '0;
      load_done <= 1'b0;
      load_data <= '0;
      load_rd   <= '0;
      overflow  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      load_done <= 1'b0;
      if (drop)
        overflow <= 1'b1;
      if (enq)
        tail <= tail + 1'b1;

      if (ld_take) begin
        if (fwd_hit) begin
          load_done <= 1'b1;
          load_data <= fwd_data;
          load_rd   <= load_rd_in;
        end else begin
          ld_valid <= 1'b1;
          ld_addr  <= addr_in;
          ld_rd    <= load_rd_in;
        end
      end

      // Requests launch only from IDLE, so every ack is followed by an idle cycle.
      case (state)
        IDLE: begin
          if (ld_valid) begin
            state     <= LD_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= ld_addr;
            mem_wdata <= '0;
          end else if (count != '0) begin
            state     <= ST_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= sq_addr[head[IW-1:0]];
            mem_wdata <= sq_data[head[IW-1:0]];
          end
        end
        LD_BUSY: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            load_done <= 1'b1;
            load_data <= mem_rdata;
            load_rd   <= ld_rd;
            ld_valid  <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            head    <= head + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ldst_mem_arbiter.sv
// Bench for ldst_mem_arbiter: vector table plus scoreboards for loads and memory writes.
module tb_ldst_mem_arbiter;
  localparam int SQ_DEPTH = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              store_fifo_write_signal, load_fifo_write_signal;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic [4:0]        load_rd_in;
  logic              load_done;
  logic [DATA_W-1:0] load_data;
  logic [4:0]        load_rd;
  logic              pipe_stall, overflow;
  logic [2:0]        sq_count;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ldst_mem_arbiter #(.SQ_DEPTH(SQ_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .store_fifo_write_signal(store_fifo_write_signal),
    .load_fifo_write_signal(load_fifo_write_signal),
    .addr_in(addr_in), .wdata_in(wdata_in), .load_rd_in(load_rd_in),
    .load_done(load_done), .load_data(load_data), .load_rd(load_rd),
    .pipe_stall(pipe_stall), .overflow(overflow), .sq_count(sq_count),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct { bit is_ld; logic [31:0] addr; logic [31:0] data; logic [4:0] rd; } vec_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; } ld_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } st_exp_t;

  int checks = 0;
  int errors = 0;
  ld_exp_t ldq[$];
  st_exp_t stq[$];
  logic [31:0] mem_model [logic [31:0]];
  int ack_delay = 1;
  bit hold_ack = 1'b0;
  bit force_ack = 1'b0;
  int wait_cnt = 0;
  st_exp_t rs;
  ld_exp_t rl;
  vec_t tbl [14];

  function automatic logic [31:0] fill(input logic [31:0] a);
    return 32'hCAFE0000 + (a >> 10);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder; it also scoreboards every write against program-order stores.
  always @(negedge clk) begin
    mem_ack <= 1'b0;
    if (force_ack) mem_ack <= 1'b1;
    else if (reset || !mem_req || mem_ack || hold_ack) wait_cnt <= 0;
    else if (wait_cnt >= ack_delay) begin
      mem_ack  <= 1'b1;
      wait_cnt <= 0;
      if (mem_we) begin
        if (stq.size() == 0) check("unexpected_write", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          rs = stq.pop_front();
          check("wr_addr", {32'h0, mem_addr}, {32'h0, rs.addr});
          check("wr_data", {32'h0, mem_wdata}, {32'h0, rs.data});
        end
        mem_model[mem_addr] = mem_wdata;
      end else
        mem_rdata <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : fill(mem_addr);
    end else wait_cnt <= wait_cnt + 1;
  end

  always @(negedge clk) begin
    if (load_done) begin
      if (ldq.size() == 0) check("unexpected_load_done", {59'h0, load_rd}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        rl = ldq.pop_front();
        check("load_data", {32'h0, load_data}, {32'h0, rl.data});
        check("load_rd", {59'h0, load_rd}, {59'h0, rl.rd});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_raw(input bit st, input bit ld, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] rd);
    store_fifo_write_signal = st; load_fifo_write_signal = ld;
    addr_in = a; wdata_in = d; load_rd_in = rd;
    tick();
    store_fifo_write_signal = 1'b0; load_fifo_write_signal = 1'b0;
  endtask

  // Behaves like stage 4: holds while stalled, then issues and records the expectation.
  task automatic drive_op(input vec_t v);
    int n = 0;
    while (pipe_stall && n < 200) begin tick(); n++; end
    if (pipe_stall) check("stall_timeout", 64'd1, 64'd0);
    if (v.is_ld) ldq.push_back('{data: v.data, rd: v.rd});
    else         stq.push_back('{addr: v.addr, data: v.data});
    drive_raw(!v.is_ld, v.is_ld, v.addr, v.data, v.rd);
  endtask

  task automatic wait_req(input bit we, input string name);
    int n = 0;
    while (!(mem_req && mem_we == we) && n < 100) begin tick(); n++; end
    check(name, {63'h0, mem_req && mem_we == we}, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sq_count != 0 || mem_req || ldq.size() != 0 || stq.size() != 0 || pipe_stall)
           && n < 300) begin tick(); n++; end
    check(name, {32'h0, n < 300, 31'h0}, {32'h0, 1'b1, 31'h0});
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; ldq.delete(); stq.delete();
  endtask

  initial begin
    int bad, cyc;
    tbl[0]  = '{0, 32'h100,  32'hDEADBEEF, 5'd0};
    tbl[1]  = '{1, 32'h100,  32'hDEADBEEF, 5'd1};
    tbl[2]  = '{1, 32'h400,  32'hCAFE0001, 5'd2};
    tbl[3]  = '{0, 32'h200,  32'h00000011, 5'd0};
    tbl[4]  = '{0, 32'h200,  32'h00000022, 5'd0};
    tbl[5]  = '{1, 32'h200,  32'h00000022, 5'd5};
    tbl[6]  = '{0, 32'h800,  32'h12345678, 5'd0};
    tbl[7]  = '{1, 32'hC00,  32'hCAFE0003, 5'd7};
    tbl[8]  = '{1, 32'h800,  32'h12345678, 5'd8};
    tbl[9]  = '{1, 32'h2000, 32'hCAFE0008, 5'd31};
    tbl[10] = '{0, 32'h104,  32'hA5A5A5A5, 5'd0};
    tbl[11] = '{0, 32'h108,  32'h5A5A5A5A, 5'd0};
    tbl[12] = '{1, 32'h108,  32'h5A5A5A5A, 5'd9};
    tbl[13] = '{1, 32'h104,  32'hA5A5A5A5, 5'd10};

    store_fifo_write_signal = 0; load_fifo_write_signal = 0;
    addr_in = '0; wdata_in = '0; load_rd_in = '0;
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_load_done", {63'h0, load_done}, 64'd0);
    check("rst_mem_req", {63'h0, mem_req}, 64'd0);
    check("rst_outputs", {mem_addr, mem_wdata | load_data}, 64'd0);
    check("rst_misc", {56'h0, mem_we, overflow, pipe_stall, sq_count, 2'b0}, 64'd0);
    reset = 1'b0;

    foreach (tbl[i]) drive_op(tbl[i]);
    wait_drain("table_drain");
    check("table_overflow", {63'h0, overflow}, 64'd0);

    // Single store to memory with a one-cycle ack.
    drive_op('{0, 32'h100, 32'hDEADBEEF, 5'd0});
    check("st1_count", {61'h0, sq_count}, 64'd1);
    wait_req(1'b1, "st1_req");
    check("st1_addr", {32'h0, mem_addr}, 64'h100);
    check("st1_wdata", {32'h0, mem_wdata}, 64'hDEADBEEF);
    wait_drain("st1_drain");
    check("st1_count_after", {61'h0, sq_count}, 64'd0);

    // Fill the queue with memory held off, then overflow it.
    hold_ack = 1'b1;
    for (int i = 0; i < SQ_DEPTH; i++)
      drive_op('{0, 32'h1000 + 32'(i * 4), 32'h100 + 32'(i), 5'd0});
    check("full_count", {61'h0, sq_count}, 64'd4);
    check("full_stall", {63'h0, pipe_stall}, 64'd1);
    check("full_no_ovf", {63'h0, overflow}, 64'd0);
    drive_raw(1'b1, 1'b0, 32'h1010, 32'h999, 5'd0);
    check("ovf_set", {63'h0, overflow}, 64'd1);
    check("ovf_count", {61'h0, sq_count}, 64'd4);
    hold_ack = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_sticky", {63'h0, overflow}, 64'd1);
    do_reset();
    check("ovf_cleared", {63'h0, overflow}, 64'd0);

    // Forward the youngest of two aliasing stores while memory is held off.
    hold_ack = 1'b1;
    drive_op('{0, 32'h200, 32'h11, 5'd0});
    drive_op('{0, 32'h200, 32'h22, 5'd0});
    drive_op('{1, 32'h200, 32'h22, 5'd5});
    check("fwd_done", {63'h0, load_done}, 64'd1);
    check("fwd_no_read", {62'h0, mem_req, mem_we}, 64'd3);
    tick();
    check("fwd_pulse", {63'h0, load_done}, 64'd0);
    hold_ack = 1'b0;
    wait_drain("fwd_drain");

    // A load arriving during a store waits for that store's ack.
    hold_ack = 1'b1;
    drive_op('{0, 32'h300, 32'h3333, 5'd0});
    wait_req(1'b1, "st_inflight");
    drive_op('{1, 32'h400, 32'hCAFE0001, 5'd3});
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (!(mem_req && mem_we)) bad++;
      tick();
    end
    check("no_preempt", 64'(bad), 64'd0);
    hold_ack = 1'b0;
    wait_req(1'b0, "ld_after_st");
    check("ld_addr", {32'h0, mem_addr}, 64'h400);
    wait_drain("preempt_drain");

    // Slow load: stall holds until the slot frees and load_done is one cycle wide.
    ack_delay = 3;
    drive_op('{1, 32'h500, 32'hCAFE0001, 5'd4});
    cyc = 0; bad = 0;
    while (pipe_stall && cyc < 50) begin
      if (load_done) bad++;
      tick(); cyc++;
    end
    check("slow_stall_len", {63'h0, cyc >= 4 && cyc < 50}, 64'd1);
    check("slow_early_done", 64'(bad), 64'd0);
    check("slow_done", {63'h0, load_done}, 64'd1);
    tick();
    check("slow_done_width", {63'h0, load_done}, 64'd0);
    ack_delay = 1;
    wait_drain("slow_drain");

    // Reset while a load is in flight; a late ack must be ignored.
    hold_ack = 1'b1;
    drive_raw(1'b0, 1'b1, 32'h600, 32'h0, 5'd6);
    wait_req(1'b0, "rst_ld_req");
    reset = 1'b1;
    tick();
    check("rstmid_req", {62'h0, mem_req, mem_we}, 64'd0);
    check("rstmid_outs", {mem_addr, mem_wdata | load_data}, 64'd0);
    check("rstmid_misc", {56'h0, load_done, overflow, pipe_stall, sq_count, load_rd[1:0]}, 64'd0);
    reset = 1'b0; hold_ack = 1'b0;
    ldq.delete(); stq.delete();
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (load_done || mem_req || pipe_stall) bad++;
      tick();
    end
    check("late_ack_ignored", 64'(bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
